// File: rtl/gyro_cfg_sequencer.sv
// gyro_cfg_sequencer: AXI4-Lite master that writes a block of configuration
// words into the gyro streaming core, reads every register back and reports
// done, or error with a cause code and the failing register index.
module gyro_cfg_sequencer #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = 32'h0000_0000,
    parameter int                            NUM_REGS           = 4,
    parameter int                            TIMEOUT            = 255
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            start,
    input  logic [NUM_REGS*32-1:0]          cfg_wdata,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [1:0]                      err_code,
    output logic [3:0]                      err_index,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]                      M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int         CFG_W    = NUM_REGS * 32;
    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);
    // Compared before incrementing, so the state is left when the count would reach TIMEOUT.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    localparam logic [1:0] ERR_RESP     = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE, S_ERR
    } state_t;

    state_t             state_r;
    logic [CFG_W-1:0]   cfg_r;
    logic [3:0]         idx_r;
    logic [15:0]        tcnt_r;
    logic               aw_done_r;
    logic               w_done_r;

    logic               aw_hs_s;
    logic               w_hs_s;
    logic               b_hs_s;
    logic               ar_hs_s;
    logic               r_hs_s;
    logic               last_s;
    logic               timeout_s;

    // Register address of slot i in the slave register file.
    function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] addr_of(input logic [3:0] i);
        return BASE_ADDR + {{(C_M_AXI_ADDR_WIDTH-6){1'b0}}, i, 2'b00};
    endfunction

    // Configuration word i out of the captured block.
    function automatic logic [31:0] word_at(input logic [CFG_W-1:0] blk, input logic [3:0] i);
        return 32'(blk >> {i, 5'd0});
    endfunction

    assign aw_hs_s   = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs_s    = M_AXI_WVALID  & M_AXI_WREADY;
    assign b_hs_s    = M_AXI_BVALID  & M_AXI_BREADY;
    assign ar_hs_s   = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs_s    = M_AXI_RVALID  & M_AXI_RREADY;
    assign last_s    = (idx_r == LAST_IDX);
    assign timeout_s = (tcnt_r == TO_LAST);

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = 4'b1111;

    // Abandon the current transfer and latch the failure cause and index.
    task go_err(input logic [1:0] code);
        state_r       <= S_ERR;
        busy          <= 1'b0;
        error         <= 1'b1;
        err_code      <= code;
        err_index     <= idx_r;
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
        tcnt_r        <= 16'd0;
    endtask

    // Sequencer FSM with all handshake and status outputs registered.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_r       <= S_IDLE;
            cfg_r         <= '0;
            idx_r         <= 4'd0;
            tcnt_r        <= 16'd0;
            aw_done_r     <= 1'b0;
            w_done_r      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= 2'b00;
            err_index     <= 4'd0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        cfg_r         <= cfg_wdata;
                        idx_r         <= 4'd0;
                        tcnt_r        <= 16'd0;
                        aw_done_r     <= 1'b0;
                        w_done_r      <= 1'b0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        err_code      <= 2'b00;
                        err_index     <= 4'd0;
                        M_AXI_AWADDR  <= addr_of(4'd0);
                        M_AXI_WDATA   <= word_at(cfg_wdata, 4'd0);
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        state_r       <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    // A handshake landing on the timeout cycle still counts.
                    if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) begin
                        M_AXI_AWVALID <= 1'b0;
                        M_AXI_WVALID  <= 1'b0;
                        aw_done_r     <= 1'b0;
                        w_done_r      <= 1'b0;
                        M_AXI_BREADY  <= 1'b1;
                        tcnt_r        <= 16'd0;
                        state_r       <= S_WR_RESP;
                    end else if (timeout_s) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        go_err(ERR_TIMEOUT);
                    end else begin
                        if (aw_hs_s) begin
                            M_AXI_AWVALID <= 1'b0;
                            aw_done_r     <= 1'b1;
                        end
                        if (w_hs_s) begin
                            M_AXI_WVALID <= 1'b0;
                            w_done_r     <= 1'b1;
                        end
                        tcnt_r <= tcnt_r + 16'd1;
                    end
                end
                S_WR_RESP: begin
                    if (b_hs_s) begin
                        M_AXI_BREADY <= 1'b0;
                        tcnt_r       <= 16'd0;
                        if (M_AXI_BRESP != 2'b00) begin
                            go_err(ERR_RESP);
                        end else if (last_s) begin
                            idx_r         <= 4'd0;
                            M_AXI_ARADDR  <= addr_of(4'd0);
                            M_AXI_ARVALID <= 1'b1;
                            state_r       <= S_RD_REQ;
                        end else begin
                            idx_r         <= idx_r + 4'd1;
                            M_AXI_AWADDR  <= addr_of(idx_r + 4'd1);
                            M_AXI_WDATA   <= word_at(cfg_r, idx_r + 4'd1);
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state_r       <= S_WR_REQ;
                        end
                    end else if (timeout_s) begin
                        go_err(ERR_TIMEOUT);
                    end else begin
                        tcnt_r <= tcnt_r + 16'd1;
                    end
                end
                S_RD_REQ: begin
                    if (ar_hs_s) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        tcnt_r        <= 16'd0;
                        state_r       <= S_RD_RESP;
                    end else if (timeout_s) begin
                        go_err(ERR_TIMEOUT);
                    end else begin
                        tcnt_r <= tcnt_r + 16'd1;
                    end
                end
                S_RD_RESP: begin
                    if (r_hs_s) begin
                        M_AXI_RREADY <= 1'b0;
                        tcnt_r       <= 16'd0;
                        // Response error outranks a data mismatch.
                        if (M_AXI_RRESP != 2'b00) begin
                            go_err(ERR_RESP);
                        end else if (M_AXI_RDATA != word_at(cfg_r, idx_r)) begin
                            go_err(ERR_MISMATCH);
                        end else if (last_s) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            idx_r         <= idx_r + 4'd1;
                            M_AXI_ARADDR  <= addr_of(idx_r + 4'd1);
                            M_AXI_ARVALID <= 1'b1;
                            state_r       <= S_RD_REQ;
                        end
                    end else if (timeout_s) begin
                        go_err(ERR_TIMEOUT);
                    end else begin
                        tcnt_r <= tcnt_r + 16'd1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                S_ERR: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r       <= S_IDLE;
                    busy          <= 1'b0;
                    M_AXI_AWVALID <= 1'b0;
                    M_AXI_WVALID  <= 1'b0;
                    M_AXI_BREADY  <= 1'b0;
                    M_AXI_ARVALID <= 1'b0;
                    M_AXI_RREADY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gyro_cfg_sequencer.sv
// Self-checking bench for gyro_cfg_sequencer: a configurable AXI4-Lite slave
// model plus scoreboard queues of expected write and read transactions.
module tb_gyro_cfg_sequencer;

    localparam int NREG = 4;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic              start = 1'b0;
    logic [NREG*32-1:0] cfg_wdata = '0;
    logic              busy, done, error;
    logic [1:0]        err_code;
    logic [3:0]        err_index;
    logic [31:0]       M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic [2:0]        M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic              M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
    logic              M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
    logic [1:0]        M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
    logic [31:0]       M_AXI_RDATA = 32'd0;

    gyro_cfg_sequencer #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
        .BASE_ADDR(32'h0000_0000), .NUM_REGS(NREG), .TIMEOUT(255)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_wdata(cfg_wdata),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    int checks = 0;
    int errors = 0;

    // Slave knobs and state
    int  aw_from = 0;
    int  w_from = 0;
    int  bad_b_idx = -1;
    int  bad_r_idx = -1;
    int  cyc = 0;
    int  wr_idx = 0;
    int  aw_count = 0, w_count = 0, ar_count = 0;
    bit  pend_aw = 1'b0, pend_w = 1'b0, rd_pend = 1'b0;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [31:0] mem [16];
    logic [63:0] exp_wr [$];
    logic [31:0] exp_rd [$];

    // Clock generation
    initial forever #5 ACLK = ~ACLK;

    // AXI4-Lite slave model: handshakes sampled at the falling edge,
    // responses driven just after the rising edge.
    initial begin
        bit s_aw, s_w, s_b, s_ar, s_r, s_start, s_rst;
        logic [63:0] e;
        logic [31:0] ea;
        int ri;
        forever begin
            @(negedge ACLK);
            s_aw = M_AXI_AWVALID && M_AXI_AWREADY;
            s_w  = M_AXI_WVALID && M_AXI_WREADY;
            s_b  = M_AXI_BVALID && M_AXI_BREADY;
            s_ar = M_AXI_ARVALID && M_AXI_ARREADY;
            s_r  = M_AXI_RVALID && M_AXI_RREADY;
            s_start = start;
            s_rst = !ARESETN;
            if (s_aw) begin cap_awaddr = M_AXI_AWADDR; pend_aw = 1'b1; aw_count++; end
            if (s_w)  begin cap_wdata = M_AXI_WDATA;   pend_w = 1'b1;  w_count++;  end
            if (s_ar) begin
                cap_araddr = M_AXI_ARADDR; rd_pend = 1'b1; ar_count++;
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL ar_unexpected: got addr %h, required none", cap_araddr);
                end else begin
                    ea = exp_rd.pop_front();
                    if (cap_araddr !== ea) begin
                        errors++;
                        $display("FAIL ar_addr: got %h, required %h", cap_araddr, ea);
                    end
                end
            end
            @(posedge ACLK);
            #1;
            if (s_rst) begin
                M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0;
                pend_aw = 1'b0; pend_w = 1'b0; rd_pend = 1'b0;
                wr_idx = 0; cyc = 0;
            end else begin
                cyc = s_start ? 1 : cyc + 1;
                if (s_start) wr_idx = 0;
                if (s_b) M_AXI_BVALID = 1'b0;
                if (s_r) M_AXI_RVALID = 1'b0;
                if (pend_aw && pend_w && !M_AXI_BVALID) begin
                    checks++;
                    if (exp_wr.size() == 0) begin
                        errors++;
                        $display("FAIL wr_unexpected: got %h/%h, required none", cap_awaddr, cap_wdata);
                    end else begin
                        e = exp_wr.pop_front();
                        if ({cap_awaddr, cap_wdata} !== e) begin
                            errors++;
                            $display("FAIL wr_txn: got %h/%h, required %h/%h",
                                     cap_awaddr, cap_wdata, e[63:32], e[31:0]);
                        end
                    end
                    mem[cap_awaddr[5:2]] = cap_wdata;
                    M_AXI_BRESP  = (wr_idx == bad_b_idx) ? 2'b10 : 2'b00;
                    M_AXI_BVALID = 1'b1;
                    wr_idx++;
                    pend_aw = 1'b0; pend_w = 1'b0;
                end
                if (rd_pend && !M_AXI_RVALID) begin
                    ri = int'(cap_araddr[5:2]);
                    M_AXI_RDATA  = (ri == bad_r_idx) ? 32'hDEAD_0000 : mem[ri];
                    M_AXI_RRESP  = 2'b00;
                    M_AXI_RVALID = 1'b1;
                    rd_pend = 1'b0;
                end
            end
            M_AXI_AWREADY = (cyc >= aw_from);
            M_AXI_WREADY  = (cyc >= w_from);
            M_AXI_ARREADY = 1'b1;
        end
    end

    function automatic logic [NREG*32-1:0] pack4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic push_expect(input logic [NREG*32-1:0] cfg, input int nw, input int nr);
        logic [NREG*32-1:0] tmp;
        exp_wr.delete();
        exp_rd.delete();
        for (int i = 0; i < nw; i++) begin
            tmp = cfg >> (32 * i);
            exp_wr.push_back({32'(4 * i), tmp[31:0]});
        end
        for (int i = 0; i < nr; i++) exp_rd.push_back(32'(4 * i));
    endtask

    // Start is high during cycle 0; returns at cycle 1, 2 time units after the edge.
    task automatic start_seq(input logic [NREG*32-1:0] cfg);
        @(posedge ACLK); #2;
        aw_count = 0; w_count = 0; ar_count = 0;
        cfg_wdata = cfg;
        start = 1'b1;
        @(posedge ACLK); #2;
        start = 1'b0;
    endtask

    task automatic wait_end(input int n0, output int n);
        n = n0;
        while (!(done || error) && n < 2000) begin
            @(posedge ACLK); #2;
            n++;
        end
        if (!(done || error)) begin
            checks++; errors++;
            $display("FAIL wait_end: no done/error after %0d cycles, required completion", n);
        end
    endtask

    task automatic check_queues_empty(input string tag);
        checks++;
        if (exp_wr.size() !== 0 || exp_rd.size() !== 0) begin
            errors++;
            $display("FAIL %s_queues: got %0d writes/%0d reads outstanding, required 0/0",
                     tag, exp_wr.size(), exp_rd.size());
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic [1:0] c, input logic [3:0] x);
        checks++;
        if ({done, error, err_code, err_index} !== {d, e, c, x}) begin
            errors++;
            $display("FAIL %s_status: got done=%b error=%b code=%b idx=%0d, required %b %b %b %0d",
                     tag, done, error, err_code, err_index, d, e, c, x);
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #2;
        checks++;
        if ({busy, done, error, err_code, err_index, M_AXI_AWVALID, M_AXI_WVALID,
             M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 13'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b done=%b error=%b code=%b idx=%0d valids=%b, required all 0",
                     busy, done, error, err_code, err_index,
                     {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
        end
        checks++;
        if ({M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}
            !== {96'd0, 3'd0, 3'd0, 4'hF}) begin
            errors++;
            $display("FAIL reset_bus: got aw=%h w=%h ar=%h prot=%b/%b strb=%h, required 0 0 0 000/000 f",
                     M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB);
        end
        ARESETN = 1'b1;
    endtask

    task automatic run_clean(input string tag, input logic [NREG*32-1:0] cfg);
        int n;
        push_expect(cfg, NREG, NREG);
        start_seq(cfg);
        checks++;
        if ({busy, M_AXI_AWVALID, M_AXI_WVALID} !== 3'b111) begin
            errors++;
            $display("FAIL %s_cycle1: got busy/awvalid/wvalid=%b, required 111", tag,
                     {busy, M_AXI_AWVALID, M_AXI_WVALID});
        end
        wait_end(1, n);
        checks++;
        if (n !== 4 * NREG + 1) begin
            errors++;
            $display("FAIL %s_latency: got done at cycle %0d, required %0d", tag, n, 4 * NREG + 1);
        end
        check_status(tag, 1'b1, 1'b0, 2'b00, 4'd0);
        repeat (2) @(posedge ACLK);
        #2;
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL %s_hold: got busy/done=%b, required 01", tag, {busy, done});
        end
        check_queues_empty(tag);
    endtask

    task automatic test_zero_wait();
        run_clean("zero_wait", pack4(32'd1, 32'd2, 32'd3, 32'd4));
    endtask

    task automatic test_bresp_err();
        int n;
        logic [NREG*32-1:0] cfg = pack4(32'h11, 32'h22, 32'h33, 32'h44);
        bad_b_idx = 2;
        push_expect(cfg, 3, 0);
        start_seq(cfg);
        wait_end(1, n);
        check_status("bresp", 1'b0, 1'b1, 2'b01, 4'd2);
        checks++;
        if (ar_count !== 0) begin
            errors++;
            $display("FAIL bresp_no_read: got %0d AR handshakes, required 0", ar_count);
        end
        repeat (3) @(posedge ACLK);
        #2;
        check_queues_empty("bresp");
        bad_b_idx = -1;
    endtask

    task automatic test_rdata_mismatch();
        int n;
        logic [NREG*32-1:0] cfg = pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        bad_r_idx = 1;
        push_expect(cfg, NREG, 2);
        start_seq(cfg);
        wait_end(1, n);
        check_status("mismatch", 1'b0, 1'b1, 2'b10, 4'd1);
        repeat (3) @(posedge ACLK);
        #2;
        checks++;
        if (ar_count !== 2) begin
            errors++;
            $display("FAIL mismatch_reads: got %0d AR handshakes, required 2", ar_count);
        end
        check_queues_empty("mismatch");
        bad_r_idx = -1;
    endtask

    task automatic test_timeout();
        int n;
        logic [NREG*32-1:0] cfg = pack4(32'h5, 32'h6, 32'h7, 32'h8);
        aw_from = 300;
        push_expect(cfg, 0, 0);
        start_seq(cfg);
        wait_end(1, n);
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL timeout_latency: got error at cycle %0d, required 256", n);
        end
        check_status("timeout", 1'b0, 1'b1, 2'b11, 4'd0);
        checks++;
        if ({aw_count, w_count} !== {32'd0, 32'd1}) begin
            errors++;
            $display("FAIL timeout_hs: got aw=%0d w=%0d, required aw=0 w=1", aw_count, w_count);
        end
        aw_from = 0;
    endtask

    task automatic test_ready_skew();
        int n;
        logic [NREG*32-1:0] cfg = pack4(32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004);
        aw_from = 4;
        w_from = 1;
        push_expect(cfg, NREG, NREG);
        start_seq(cfg);
        for (int k = 2; k <= 4; k++) begin
            @(posedge ACLK); #2;
            checks++;
            if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b10) begin
                errors++;
                $display("FAIL skew_valids_c%0d: got aw/w valid=%b, required 10", k,
                         {M_AXI_AWVALID, M_AXI_WVALID});
            end
        end
        wait_end(4, n);
        check_status("skew", 1'b1, 1'b0, 2'b00, 4'd0);
        checks++;
        if ({aw_count, w_count} !== {32'(NREG), 32'(NREG)}) begin
            errors++;
            $display("FAIL skew_hs: got aw=%0d w=%0d, required %0d each", aw_count, w_count, NREG);
        end
        check_queues_empty("skew");
        aw_from = 0;
        w_from = 0;
    endtask

    task automatic test_busy_start();
        int n;
        logic [NREG*32-1:0] cfg = pack4(32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10);
        push_expect(cfg, NREG, NREG);
        start_seq(cfg);
        @(posedge ACLK); #2;
        cfg_wdata = pack4(32'hFFFF_0000, 32'hFFFF_0001, 32'hFFFF_0002, 32'hFFFF_0003);
        start = 1'b1;
        @(posedge ACLK); #2;
        start = 1'b0;
        wait_end(3, n);
        checks++;
        if (n !== 4 * NREG + 1) begin
            errors++;
            $display("FAIL busy_start_latency: got done at cycle %0d, required %0d", n, 4 * NREG + 1);
        end
        check_status("busy_start", 1'b1, 1'b0, 2'b00, 4'd0);
        check_queues_empty("busy_start");
    endtask

    task automatic test_reset_midread();
        int k;
        logic [NREG*32-1:0] cfg = pack4(32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000);
        push_expect(cfg, NREG, NREG);
        start_seq(cfg);
        k = 0;
        while (!(M_AXI_RREADY && ar_count == 3) && k < 100) begin
            @(posedge ACLK); #2;
            k++;
        end
        checks++;
        if (!(M_AXI_RREADY && ar_count == 3)) begin
            errors++;
            $display("FAIL midread_reach: got rready=%b ar=%0d, required 1 and 3", M_AXI_RREADY, ar_count);
        end
        ARESETN = 1'b0;
        @(posedge ACLK); #2;
        checks++;
        if ({busy, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 6'd0) begin
            errors++;
            $display("FAIL midread_reset: got busy+valids=%b, required 000000",
                     {busy, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
        end
        ARESETN = 1'b1;
        exp_wr.delete();
        exp_rd.delete();
        repeat (2) @(posedge ACLK);
        run_clean("after_reset", pack4(32'hBEEF_0001, 32'hBEEF_0002, 32'hBEEF_0003, 32'hBEEF_0004));
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_zero_wait();
        test_bresp_err();
        test_rdata_mismatch();
        test_timeout();
        test_ready_skew();
        test_busy_start();
        test_reset_midread();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gyro_cfg_sequencer.md
# gyro_cfg_sequencer

AXI4-Lite master that brings up the gyro streaming IP. On `start` it writes a block of configuration words into the IP's slave register file at consecutive 4-byte addresses. It then reads every register back, compares each word against the value written, and reports done or error with a cause and register index. It sits between the platform control logic and the S00_AXI port of the gyro streaming core, so the core is configured without processor involvement.

## Interface
Parameters:
- `C_M_AXI_ADDR_WIDTH`, 32, address width.
- `C_M_AXI_DATA_WIDTH`, 32, data width; only 32 is supported.
- `BASE_ADDR`, 32'h0000_0000, address of register 0.
- `NUM_REGS`, 4, number of registers to write and verify (1..16).
- `TIMEOUT`, 255, maximum cycles spent waiting on any single handshake.

Ports:
- `ACLK` in 1: clock. One clock domain; all logic is on the rising edge.
- `ARESETN` in 1: reset, synchronous, active-low.
- `start` in 1: pulse that begins a sequence; sampled only in IDLE.
- `cfg_wdata` in NUM_REGS*32: word i is in bits [32i+31:32i]; captured on the start cycle.
- `busy` out 1: high from the cycle after start until DONE/ERR.
- `done` out 1: sequence passed; held until the next start.
- `error` out 1: sequence failed; held until the next start.
- `err_code` out 2: 00 none, 01 bad BRESP/RRESP, 10 readback mismatch, 11 timeout.
- `err_index` out 4: index of the register that failed.
- `M_AXI_AWADDR` out ADDR; `M_AXI_AWPROT` out 3 (constant 000); `M_AXI_AWVALID` out 1; `M_AXI_AWREADY` in 1.
- `M_AXI_WDATA` out 32; `M_AXI_WSTRB` out 4 (constant 1111); `M_AXI_WVALID` out 1; `M_AXI_WREADY` in 1.
- `M_AXI_BRESP` in 2; `M_AXI_BVALID` in 1; `M_AXI_BREADY` out 1.
- `M_AXI_ARADDR` out ADDR; `M_AXI_ARPROT` out 3 (constant 000); `M_AXI_ARVALID` out 1; `M_AXI_ARREADY` in 1.
- `M_AXI_RDATA` in 32; `M_AXI_RRESP` in 2; `M_AXI_RVALID` in 1; `M_AXI_RREADY` out 1.

## Operation
States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, ERR.
- IDLE + start: capture `cfg_wdata`, set idx=0, clear done/error/err_code/err_index, go to WR_REQ.
- WR_REQ:
  - AWVALID and WVALID rise together, with AWADDR = BASE_ADDR + 4*idx and WDATA = word idx.
  - Each valid drops independently on its own handshake (the valid/ready cycle). Each channel handshakes exactly once.
  - Once both handshakes have completed, go to WR_RESP.
- WR_RESP: BREADY high. On BVALID:
  - BRESP != 00 → ERR with code 01.
  - Otherwise, if idx = NUM_REGS-1 then idx=0 and go to RD_REQ; else idx++ and go to WR_REQ.
- RD_REQ: ARVALID high with ARADDR = BASE_ADDR + 4*idx. On ARREADY go to RD_RESP.
- RD_RESP: RREADY high. On RVALID:
  - RRESP != 00 → ERR with code 01.
  - RDATA != word idx → ERR with code 10.
  - Otherwise, if idx is the last register go to DONE; else idx++ and go to RD_REQ.
- Timeout: a counter clears on every state entry and increments each cycle spent in WR_REQ, WR_RESP, RD_REQ or RD_RESP. If it reaches TIMEOUT, go to ERR with code 11.
- Error priority within one cycle: response error over mismatch. A handshake completing in the same cycle as the timeout counter reaching TIMEOUT wins; no error is flagged.
- On entry to ERR, `err_index` = idx.
- DONE: done=1. ERR: error=1. Both states return to IDLE the next cycle; flags and err_* hold.
- A `start` asserted while busy is ignored.
- The write phase always completes before any read is issued. No read is issued after a write error.

## Timing
- Reset (ARESETN low at a rising edge): all valid/ready outputs 0, busy/done/error 0, err_code 00, err_index 0, AWADDR/WDATA/ARADDR 0, state IDLE.
  - Reset mid-transaction abandons it; valids are low from the first edge with ARESETN low.
- Start at cycle 0: busy=1 and AWVALID=WVALID=1 at cycle 1.
- All outputs are registered; no combinational path from any input to any output.
- With slave ready/valid responding in the same or next cycle, per register:
  - write = 2 cycles (request, response);
  - read = 2 cycles.
- Total with zero-wait slave = 4*NUM_REGS cycles to DONE entry; done rises on the following edge.
- VALID, once raised, is held with stable address/data until its handshake completes (AXI rule).

## Test plan
- Zero-wait slave model, cfg = 1,2,3,4 → writes 1,2,3,4 to 0x0/0x4/0x8/0xC, reads return the same words, done=1 after 16+1 cycles, error=0.
- Slave returns BRESP=10 on the 3rd write → error=1, err_code=01, err_index=2, zero AR handshakes seen.
- Slave RDATA for register 1 returns 0xDEAD0000 → err_code=10, err_index=1, no read of register 2.
- AWREADY held low for 300 cycles on register 0 → err_code=11, err_index=0 after 255 cycles in WR_REQ.
- WREADY at cycle 1, AWREADY at cycle 4 → exactly one W and one AW handshake; WVALID low from cycle 2; sequence still passes.
- ARESETN low for one cycle during RD_RESP of register 2 → all valids and busy low on the next edge. A new start then passes cleanly with done=1.
